// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the burst fetch sequencer
package fetch_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo2.sv
// rtl/sync_fifo2.sv - two-entry synchronous FIFO with registered count and valid flag
module sync_fifo2
    import fetch_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;
    logic [1:0]   count_next;

    // A push into a full FIFO is only accepted when the same cycle pops.
    always_comb begin
        do_pop     = pop & valid;
        do_push    = push & ((count != 2'd2) | do_pop);
        count_next = count;
        if (do_push & ~do_pop) begin
            count_next = count + 2'd1;
        end else if (do_pop & ~do_push) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            valid  <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
            valid <= (count_next != 2'd0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - burst read sequencer driving an external address generator
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_sel,
    output logic              pc_en,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    fetch_state_t     state;
    logic [CNT_W-1:0] remaining;
    logic             rd_pending;
    logic [1:0]       fifo_count;
    logic [2:0]       occupancy;
    logic             pop;
    logic             in_load;
    logic             issue;
    logic             base_unused;

    // base_addr is consumed by the address generator itself during LOAD.
    assign base_unused = ^base_addr;

    // Words buffered plus in flight, net of this cycle's pop; a new read may
    // only be issued while that leaves room in the two-entry buffer.
    assign pop       = out_valid & out_ready;
    assign occupancy = 3'(fifo_count) + 3'(rd_pending) - 3'(pop);
    assign in_load   = ~rst & (state == ST_LOAD);
    assign issue     = ~rst & (state == ST_ISSUE) & (occupancy < 3'd2);

    assign pc_sel   = in_load;
    assign pc_en    = in_load | issue;
    assign mem_rd   = issue;
    assign mem_addr = pc_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            rd_pending <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            rd_pending <= mem_rd;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            remaining <= num_words;
                            state     <= ST_LOAD;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (issue) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (~rd_pending &&
                        ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo2 #(
        .W(DATA_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rd_pending),
        .wdata(mem_rdata),
        .pop  (pop),
        .count(fifo_count),
        .valid(out_valid),
        .head (out_data)
    );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - randomized self-checking bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  num_words = '0;
    logic [ADDR_W-1:0] pc_addr = '0;
    logic              pc_sel;
    logic              pc_en;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic              out_valid;
    logic [31:0]       out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem_salt = 32'h1234_5678;

    always #5 clk = ~clk;

    fetch_seq_ctrl #(
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .num_words(num_words),
        .pc_addr  (pc_addr),
        .pc_sel   (pc_sel),
        .pc_en    (pc_en),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ mem_salt;
    endfunction

    // Environment: address generator and memory, acting on what the DUT drove before the edge
    logic        env_rd, env_en, env_sel;
    logic [31:0] env_addr, env_base;

    always @(negedge clk) begin
        env_rd   = mem_rd;
        env_en   = pc_en;
        env_sel  = pc_sel;
        env_addr = mem_addr;
        env_base = base_addr;
    end

    always @(posedge clk) begin
        #1;
        mem_rdata = env_rd ? mem_word(env_addr) : $urandom;
        if (env_en) pc_addr = env_sel ? env_base : pc_addr + 32'd4;
    end

    // Reference model: expected address/data queues per accepted burst
    int          cyc = 0;
    int          done_due = -1;
    int          load_due = -1;
    bit          m_busy = 1'b0;
    int          outstanding = 0;
    int          rd_total = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    always @(negedge clk) begin : monitor
        bit popped;
        cyc++;
        popped = 1'b0;
        if (rst) begin
            exp_addr.delete();
            exp_data.delete();
            m_busy      = 1'b0;
            done_due    = -1;
            load_due    = -1;
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            check("busy", busy, m_busy);
            check("done", done, cyc == done_due);
            if (cyc == load_due) check("load_strobes", {pc_sel, pc_en, mem_rd}, 3'b110);
            if (!m_busy) check("idle_strobes", {pc_en, mem_rd}, 2'b00);
            if (mem_rd) begin
                rd_total++;
                outstanding++;
                check("rd_pc_ctrl", {pc_en, pc_sel}, 2'b10);
                if (exp_addr.size() == 0) check("extra_rd", 1, 0);
                else check("rd_addr", mem_addr, exp_addr.pop_front());
            end
            if (prev_stall) check("hold_stable", {out_valid, out_data}, {1'b1, prev_data});
            if (out_valid && out_ready) begin
                outstanding--;
                popped = 1'b1;
                if (exp_data.size() == 0) check("extra_word", 1, 0);
                else check("out_data", out_data, exp_data.pop_front());
            end
            if (mem_rd) check("buffered_le2", outstanding <= 2, 1);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (start && !m_busy) begin
                if (num_words == 0) begin
                    done_due = cyc + 1;
                end else begin
                    for (int i = 0; i < int'(num_words); i++) begin
                        exp_addr.push_back(base_addr + 32'(4 * i));
                        exp_data.push_back(mem_word(base_addr + 32'(4 * i)));
                    end
                    m_busy   = 1'b1;
                    load_due = cyc + 1;
                end
            end else if (m_busy && popped && exp_addr.size() == 0 && exp_data.size() == 0) begin
                done_due = cyc + 1;
                m_busy   = 1'b0;
            end
        end
    end

    // mode 0: ready always high, 1: ready low for cycles 4..9, 2: random ready
    task automatic run_burst(input logic [31:0] b, input int n, input int mode, input bit junk);
        bit got_done;
        int rd_before;
        rd_before = rd_total;
        got_done  = 1'b0;
        @(posedge clk);
        #1;
        base_addr = b;
        num_words = CNT_W'(n);
        start     = 1'b1;
        out_ready = (mode == 2) ? ($urandom % 4 != 0) : 1'b1;
        for (int i = 0; i < 200 && !got_done; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            case (mode)
                1:       out_ready = !((i + 1) >= 4 && (i + 1) <= 9);
                2:       out_ready = ($urandom % 4 != 0);
                default: out_ready = 1'b1;
            endcase
            if (junk && m_busy && ($urandom % 5 == 0)) begin
                start     = 1'b1;
                num_words = CNT_W'($urandom_range(0, 255));
            end
        end
        start = 1'b0;
        check("burst_done_seen", got_done, 1);
        check("burst_rd_count", rd_total - rd_before, n);
        if (!got_done) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        mem_salt = $urandom;
        repeat (2) @(posedge clk);
        #1;
        start     = 1'b1;
        num_words = 8'd3;
        base_addr = 32'h40;
        @(negedge clk);
        check("reset_outputs", {busy, done, out_valid, pc_en, pc_sel, mem_rd}, 6'b0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset_beats_start", {busy, done, pc_en}, 3'b0);

        // Four words at full throughput: timeline relative to the start cycle
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        base_addr = 32'h100;
        num_words = 8'd4;
        start     = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("timeline_c%0d", i), {mem_rd, out_valid, done, busy, pc_sel},
                  {(i >= 2 && i <= 5), (i >= 4 && i <= 7), (i == 8), (i >= 1 && i <= 7), (i == 1)});
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        // Zero-length burst
        base_addr = 32'h200;
        num_words = 8'd0;
        start     = 1'b1;
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            check($sformatf("zero_len_c%0d", i), {done, busy, mem_rd, pc_en}, {(i == 1), 3'b000});
            @(posedge clk);
            #1;
            start = 1'b0;
        end

        run_burst(32'h3000, 6, 1, 1'b0);
        run_burst(32'hFFFF_FFFC, 2, 0, 1'b1);

        // Reset with the first read still in flight
        base_addr = 32'h5000;
        num_words = 8'd6;
        out_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_case_first_rd", mem_rd, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("after_rst_state", {busy, out_valid, done, mem_rd, pc_en, pc_sel}, 6'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("after_rst_no_data", out_valid, 0);
        end
        run_burst(32'h6000, 5, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            run_burst($urandom, $urandom_range(0, 9), 2, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
